// File: rtl/equiv_bist_if.sv
// Stimulus/response bundle between the BIST controller and its environment.
// master: the BIST controller side; slave: the test environment (DUT, reference model, host).
interface equiv_bist_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic             f_dut;
  logic             f_ref;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;

  modport master (
    input  start, f_dut, f_ref,
    output stim, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, f_dut, f_ref,
    input  stim, busy, done, pass, err_cnt, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/equiv_bist.sv
// Exhaustive DUT-vs-reference comparator for small combinational blocks.
// Optional BIST_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module equiv_bist #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  equiv_bist_if.master bus
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] RELOAD = SW'(SETTLE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [SW-1:0]    cnt;
  logic [N_IN-1:0]  stim_q;
  logic [CNT_W-1:0] err_q;
  logic             pass_q;
  logic [N_IN-1:0]  ffv_q;
  logic             ffvalid_q;
  logic             mismatch;
  logic             stop_run;

  always_comb begin
    mismatch = bus.f_dut ^ bus.f_ref;
`ifdef BIST_STOP_ON_FAIL_EN
    stop_run = mismatch || (&stim_q);
`else
    stop_run = &stim_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stim_q    <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_SETTLE;
            err_q     <= '0;
            pass_q    <= 1'b0;
            ffvalid_q <= 1'b0;
            stim_q    <= '0;
            cnt       <= RELOAD;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_CHECK;
          else           cnt   <= cnt - SW'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            if (!(&err_q)) err_q <= err_q + CNT_W'(1);
            if (!ffvalid_q) begin
              ffv_q     <= stim_q;
              ffvalid_q <= 1'b1;
            end
          end
          if (stop_run) begin
            state  <= S_DONE;
            // Verdict is registered on entry to DONE so it is already valid while done pulses.
            pass_q <= (err_q == '0) && !mismatch;
          end else begin
            stim_q <= stim_q + N_IN'(1);
            cnt    <= RELOAD;
            state  <= S_SETTLE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stim             = stim_q;
  assign bus.busy             = (state == S_SETTLE) || (state == S_CHECK);
  assign bus.done             = (state == S_DONE);
  assign bus.pass             = pass_q;
  assign bus.err_cnt          = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;
endmodule

// File: doc/equiv_bist.md
# equiv_bist

Hardware self-checking harness for small combinational blocks. It drives every input vector in turn to a device under test and a reference model that share the `stim` bus. After a settle interval it compares their single-bit outputs, counts mismatches, and reports pass/fail. It brings the exhaustive DUT-versus-reference comparison on chip, so gate-level units (XOR and the rest of the primitive set) can be checked in silicon or FPGA without a simulator.

## Interface
Parameters:
- `N_IN`, 2, number of stimulus bits; `2**N_IN` vectors are applied.
- `SETTLE`, 1, clock cycles each vector is held before sampling; legal range ≥ 1.
- `CNT_W`, 8, width of the mismatch counter.

Ports:
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begins a run when sampled high in IDLE.
- `f_dut`  in  1  output of the device under test.
- `f_ref`  in  1  output of the reference model.
- `stim`  out  N_IN  stimulus vector; `stim[0]` drives input A, `stim[1]` drives input B.
- `busy`  out  1  high from the first SETTLE cycle through the last CHECK cycle.
- `done`  out  1  one-cycle pulse when a run ends.
- `pass`  out  1  1 when the last completed run had zero mismatches; held until the next accepted start.
- `err_cnt`  out  CNT_W  mismatch count; saturates at all-ones.
- `first_fail_vec`  out  N_IN  vector index of the first mismatch.
- `first_fail_valid`  out  1  high once any mismatch has been captured in the current or last run.

## Operation
- Reset values (synchronous, `rst_n`=0 at an edge):
  - FSM to IDLE.
  - `stim`, `err_cnt`, `first_fail_vec` all 0.
  - `busy`, `done`, `pass`, `first_fail_valid` all 0.
- FSM states:
  - **IDLE → SETTLE** on `start`=1. On acceptance: clear `err_cnt`, `pass`, `first_fail_valid`; `stim`←0; settle counter←SETTLE−1.
  - **SETTLE**: count down each cycle. At 0, go to CHECK.
  - **CHECK**: sample `f_dut` and `f_ref`.
    - On mismatch: increment `err_cnt` (saturating at all-ones).
    - On the first mismatch of the run: capture `first_fail_vec`←`stim` and set `first_fail_valid`.
    - If `stim` = 2**N_IN−1: go to DONE.
    - Otherwise: `stim`←`stim`+1, reload the settle counter, go to SETTLE.
  - **DONE**: `done`=1 for exactly this cycle; `pass`←(`err_cnt`==0, including the final CHECK result); go to IDLE.
- Vector order is binary increment. For N_IN=2 the sequence in (A,B) form is 00, 10, 01, 11.
- `start` is ignored outside IDLE. A `start` in the DONE cycle is ignored; a `start` held high re-launches on the following IDLE cycle.
- `stim` holds its last vector after the run ends and in IDLE; it is only reset by `rst_n` or a new start.
- Reset mid-run aborts immediately at the next edge. All outputs return to reset values and no `done` is issued.
- The comparison is a two-state equality (`f_dut` != `f_ref`). X/Z handling is out of scope.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles of settling plus 1 CHECK cycle.
- With `start` sampled at edge t:
  - `busy` rises at t+1.
  - `done` pulses in cycle t+1+2**N_IN·(SETTLE+1).
  - `busy` is low in the DONE cycle.
- Defaults (N_IN=2, SETTLE=1): `done` at t+9.
- `stim` changes on the edge that leaves CHECK, so the DUT sees a stable vector for the full settle window.
- `pass`, `err_cnt`, `first_fail_*` are valid in the DONE cycle and remain stable until the next accepted start.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatching CHECK goes directly to DONE; remaining vectors are skipped.
  - `err_cnt` ends at 1 and `pass`=0.
  - `done` arrives early at t+1+(k+1)·(SETTLE+1), where k is the failing vector index.
- `BIST_STOP_ON_FAIL_EN` undefined (default): every vector is always applied and all mismatches are counted.

## Test plan
- **Good DUT:** XOR as both DUT and reference, defaults, `start` pulse at t → `stim` walks 0,1,2,3; `done` at t+9; `pass`=1; `err_cnt`=0; `first_fail_valid`=0.
- **Faulty DUT:** `f_dut` tied 0, reference XOR → `err_cnt`=2; `first_fail_vec`=1; `first_fail_valid`=1; `pass`=0; `done` at t+9.
- **Stop on fail:** with `BIST_STOP_ON_FAIL_EN` and the same fault → `done` at t+5; `err_cnt`=1; `first_fail_vec`=1.
- **Saturation:** CNT_W=1, `f_dut`=~`f_ref` → `err_cnt`=1 (saturated, no wrap); `pass`=0.
- **Reset mid-run:** `rst_n` low for one edge during vector 2 → next cycle `busy`=0, `stim`=0, `err_cnt`=0; no `done` pulse.
- **Start handling:** `start` held high continuously → `start` pulses during the run are ignored; after each `done`, one idle cycle, then a new run with `err_cnt` cleared; the second `done` comes 10 cycles after the first.
